// File: rtl/fifo_skew_reader_if.sv
// Read-side bundle between the input FIFO bank, the skew reader and the PE array rows.
// Handshake: start is a one-cycle request; r_en[i] pops FIFO i and the popped word is on
// fifo_data row i the following cycle; row_valid[i] qualifies row_data row i (zero when low).
interface fifo_skew_reader_if #(
   parameter int DATA_SIZE  = 8,
   parameter int ARRAY_SIZE = 3
);
   logic                            start;
   logic [ARRAY_SIZE-1:0]           empty;
   logic [ARRAY_SIZE*DATA_SIZE-1:0] fifo_data;
   logic [ARRAY_SIZE-1:0]           r_en;
   logic [ARRAY_SIZE*DATA_SIZE-1:0] row_data;
   logic [ARRAY_SIZE-1:0]           row_valid;
   logic                            busy;
   logic                            done;

   modport master (
      output start, empty, fifo_data,
      input  r_en, row_data, row_valid, busy, done
   );

   modport slave (
      input  start, empty, fifo_data,
      output r_en, row_data, row_valid, busy, done
   );
endinterface

// File: rtl/fifo_skew_reader.sv
// Drains ARRAY_SIZE FIFOs into the systolic array rows with a one-cycle diagonal skew per row;
// all rows stall together on any active-row empty so the skew is never disturbed.
module fifo_skew_reader #(
   parameter int DATA_SIZE  = 8,
   parameter int ARRAY_SIZE = 3,
   parameter int VEC_LEN    = 9
) (
   input  logic              s_clk,
   input  logic              clear,
   fifo_skew_reader_if.slave bus,
   output logic [1:0]        dbg_state_o
);
   localparam int LAST = VEC_LEN + ARRAY_SIZE - 2;
   localparam int TW   = $clog2(VEC_LEN + ARRAY_SIZE);
   localparam logic [TW-1:0] LAST_T = TW'(LAST);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                          state_q, state_d;
   logic [TW-1:0]                   t_q, t_d;
   logic                            flush_q, flush_d;
   logic [ARRAY_SIZE-1:0]           pend_q;
   logic [ARRAY_SIZE-1:0]           row_valid_q;
   logic [ARRAY_SIZE*DATA_SIZE-1:0] row_data_q;
   logic                            done_q;
   logic [ARRAY_SIZE-1:0]           active;
   logic [ARRAY_SIZE-1:0]           r_en;
   logic                            run;
   logic                            stall;

   // Row i owns the window i <= t < i+VEC_LEN of the diagonal schedule.
   always_comb begin
      active = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         active[i] = (int'(t_q) >= i) && (int'(t_q) < i + VEC_LEN);
      end
   end

   assign run   = (state_q == RUN);
   assign stall = run && (|(active & bus.empty));
   assign r_en  = (run && !stall) ? active : '0;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      flush_d = flush_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               t_d     = '0;
            end
         end
         RUN: begin
            if (!stall) begin
               if (t_q == LAST_T) begin
                  state_d = FLUSH;
                  flush_d = 1'b0;
               end else begin
                  t_d = t_q + TW'(1);
               end
            end
         end
         FLUSH: begin
            // Two cycles let the last pop travel through pend and row registers.
            if (flush_q) begin
               state_d = DONE;
            end else begin
               flush_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge s_clk or posedge clear) begin
      if (clear) begin
         state_q     <= IDLE;
         t_q         <= '0;
         flush_q     <= 1'b0;
         pend_q      <= '0;
         row_valid_q <= '0;
         row_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         flush_q     <= flush_d;
         pend_q      <= r_en;
         row_valid_q <= pend_q;
         done_q      <= (state_q == DONE);
         for (int i = 0; i < ARRAY_SIZE; i++) begin
            row_data_q[i*DATA_SIZE +: DATA_SIZE] <=
               pend_q[i] ? bus.fifo_data[i*DATA_SIZE +: DATA_SIZE] : '0;
         end
      end
   end

   assign bus.r_en      = r_en;
   assign bus.row_valid = row_valid_q;
   assign bus.row_data  = row_data_q;
   assign bus.busy      = run || (state_q == FLUSH);
   assign bus.done      = done_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_fifo_skew_reader.sv
// Bench for fifo_skew_reader: FIFO bank model, per-cycle vector table for a clean burst,
// hand sequences for stall, start-while-busy, mid-burst clear, back-to-back and a 1x1 instance.
module tb_fifo_skew_reader;
   localparam int DW = 8;
   localparam int AS = 3;
   localparam int VL = 9;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic s_clk = 1'b0;
   logic clear;
   logic [1:0] dbg_a, dbg_b;
   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   always #5 s_clk = ~s_clk;
   always @(posedge s_clk) cyc <= cyc + 1;

   fifo_skew_reader_if #(.DATA_SIZE(DW), .ARRAY_SIZE(AS)) bus ();
   fifo_skew_reader_if #(.DATA_SIZE(DW), .ARRAY_SIZE(1))  bus_b ();

   fifo_skew_reader #(.DATA_SIZE(DW), .ARRAY_SIZE(AS), .VEC_LEN(VL)) dut (
      .s_clk       (s_clk),
      .clear       (clear),
      .bus         (bus.slave),
      .dbg_state_o (dbg_a)
   );

   fifo_skew_reader #(.DATA_SIZE(DW), .ARRAY_SIZE(1), .VEC_LEN(1)) dut_b (
      .s_clk       (s_clk),
      .clear       (clear),
      .bus         (bus_b.slave),
      .dbg_state_o (dbg_b)
   );

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- FIFO bank model ----------------
   logic [DW-1:0] fq[AS][$];
   logic [AS-1:0] fifo_pop;

   initial begin
      bus.fifo_data = '0;
      bus.empty     = '1;
      forever begin
         @(negedge s_clk);
         fifo_pop = bus.r_en;
         @(posedge s_clk);
         if (clear) fifo_pop = '0;
         #1;
         for (int i = 0; i < AS; i++) begin
            if (fifo_pop[i] && fq[i].size() > 0) bus.fifo_data[i*DW +: DW] = fq[i].pop_front();
            bus.empty[i] = (fq[i].size() == 0);
         end
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [DW-1:0] exp_q[AS][$];
   logic [AS-1:0] ren_tr[2048];
   logic [AS-1:0] rv_tr[2048];
   int pops[AS];
   int ren_last[AS];
   int rv_last[AS];
   int done_cnt, done_cyc, viol;
   bit mon_en = 1'b0;

   always @(negedge s_clk) begin
      if (mon_en) begin
         if (cyc < 2048) begin
            ren_tr[cyc] = bus.r_en;
            rv_tr[cyc]  = bus.row_valid;
         end
         for (int i = 0; i < AS; i++) begin
            if (bus.r_en[i] && bus.empty[i]) viol++;
            if (bus.r_en[i]) begin
               pops[i]++;
               ren_last[i] = cyc;
            end
            if (bus.row_valid[i]) begin
               rv_last[i] = cyc;
               if (exp_q[i].size() == 0) chk($sformatf("row%0d_extra_word", i), 1, 0);
               else chk($sformatf("row%0d_data", i), bus.row_data[i*DW +: DW], exp_q[i].pop_front());
            end else begin
               chk($sformatf("row%0d_bubble_zero", i), bus.row_data[i*DW +: DW], 0);
            end
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic reset_log();
      for (int i = 0; i < AS; i++) begin
         pops[i]     = 0;
         ren_last[i] = -1;
         rv_last[i]  = -1;
      end
      done_cnt = 0;
      done_cyc = -1;
      viol     = 0;
   endtask

   task automatic load_row(input int i, input int n_fifo, input int n_exp, input int k0);
      for (int k = 0; k < n_fifo; k++) fq[i].push_back(DW'(16 * (i + 1) + k0 + k));
      for (int k = 0; k < n_exp; k++) exp_q[i].push_back(DW'(16 * (i + 1) + k0 + k));
   endtask

   // Called at a negedge; returns the edge number that sampled start.
   task automatic pulse_start(output int e0);
      bus.start = 1'b1;
      @(negedge s_clk);
      bus.start = 1'b0;
      e0 = cyc;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge s_clk);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (!bus.done && n < limit) begin
         @(negedge s_clk);
         n++;
      end
      chk("done_seen", bus.done, 1);
      @(negedge s_clk);
   endtask

   task automatic check_burst(input string tag, input int n_words);
      chk({tag, "_viol"}, viol, 0);
      for (int i = 0; i < AS; i++) begin
         chk($sformatf("%s_pops%0d", tag, i), pops[i], n_words);
         chk($sformatf("%s_expq%0d", tag, i), exp_q[i].size(), 0);
      end
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      logic               start;
      logic [AS-1:0]      r_en;
      logic [AS-1:0]      rv;
      logic [AS*DW-1:0]   data;
      logic               busy;
      logic               done;
   } vec_t;

   typedef struct {
      logic          start;
      logic          r_en;
      logic          rv;
      logic [DW-1:0] data;
      logic          busy;
      logic          done;
   } cvec_t;

   vec_t  tv[18];
   cvec_t cv[7];

   initial begin
      int e0, e1;
      // Clean burst with start sampled at table edge 1.
      for (int c = 0; c < 18; c++) begin
         tv[c].start = (c == 0);
         tv[c].r_en  = '0;
         tv[c].rv    = '0;
         tv[c].data  = '0;
         tv[c].busy  = (c >= 1 && c <= 13);
         tv[c].done  = (c == 15);
         for (int i = 0; i < AS; i++) begin
            if (c >= 1 + i && c <= 9 + i) tv[c].r_en[i] = 1'b1;
            if (c >= 3 + i && c <= 11 + i) begin
               tv[c].rv[i] = 1'b1;
               tv[c].data[i*DW +: DW] = DW'(16 * (i + 1) + c - 3 - i);
            end
         end
      end
      // 1x1 instance: pop at E0, valid at E0+2, done at E0+4.
      cv[0] = '{start: 1'b1, r_en: 1'b0, rv: 1'b0, data: 8'h00, busy: 1'b0, done: 1'b0};
      cv[1] = '{start: 1'b0, r_en: 1'b1, rv: 1'b0, data: 8'h00, busy: 1'b1, done: 1'b0};
      cv[2] = '{start: 1'b0, r_en: 1'b0, rv: 1'b0, data: 8'h00, busy: 1'b1, done: 1'b0};
      cv[3] = '{start: 1'b0, r_en: 1'b0, rv: 1'b1, data: 8'h5A, busy: 1'b1, done: 1'b0};
      cv[4] = '{start: 1'b0, r_en: 1'b0, rv: 1'b0, data: 8'h00, busy: 1'b0, done: 1'b0};
      cv[5] = '{start: 1'b0, r_en: 1'b0, rv: 1'b0, data: 8'h00, busy: 1'b0, done: 1'b1};
      cv[6] = '{start: 1'b0, r_en: 1'b0, rv: 1'b0, data: 8'h00, busy: 1'b0, done: 1'b0};

      // ---------------- clock/reset ----------------
      bus.start       = 1'b0;
      bus_b.start     = 1'b0;
      bus_b.empty     = 1'b0;
      bus_b.fifo_data = 8'h5A;
      reset_log();
      clear = 1'b1;
      repeat (2) @(negedge s_clk);
      chk("rst_r_en", bus.r_en, 0);
      chk("rst_row_valid", bus.row_valid, 0);
      chk("rst_row_data", bus.row_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_state", dbg_a, ST_IDLE);
      chk("rst_state_b", dbg_b, ST_IDLE);
      clear = 1'b0;
      @(negedge s_clk);

      // ---------------- basic burst, table driven ----------------
      for (int i = 0; i < AS; i++) load_row(i, VL, 0, 0);
      @(negedge s_clk);
      for (int c = 0; c < 18; c++) begin
         if (c > 0) @(negedge s_clk);
         chk($sformatf("basic_c%0d_r_en", c), bus.r_en, tv[c].r_en);
         chk($sformatf("basic_c%0d_valid", c), bus.row_valid, tv[c].rv);
         chk($sformatf("basic_c%0d_data", c), bus.row_data, tv[c].data);
         chk($sformatf("basic_c%0d_busy", c), bus.busy, tv[c].busy);
         chk($sformatf("basic_c%0d_done", c), bus.done, tv[c].done);
         bus.start = tv[c].start;
      end
      bus.start = 1'b0;
      mon_en = 1'b1;

      // ---------------- empty stall on FIFO 1 ----------------
      reset_log();
      load_row(0, VL, VL, 0);
      load_row(1, 4, VL, 0);
      load_row(2, VL, VL, 0);
      @(negedge s_clk);
      pulse_start(e0);
      wait_cyc(e0 + 7);
      load_row(1, 5, 0, 4);
      wait_done(40);
      for (int d = 5; d <= 7; d++) chk($sformatf("stall_r_en_off_%0d", d), ren_tr[e0 + d], 0);
      for (int d = 7; d <= 9; d++) chk($sformatf("stall_bubble_%0d", d), rv_tr[e0 + d], 0);
      chk("stall_valid_before", rv_tr[e0 + 6], 3'b111);
      chk("stall_valid_after", rv_tr[e0 + 10], 3'b111);
      for (int i = 0; i < AS; i++) begin
         chk($sformatf("stall_ren_last%0d", i), ren_last[i], e0 + 11 + i);
         chk($sformatf("stall_rv_last%0d", i), rv_last[i], e0 + 13 + i);
      end
      chk("stall_done_cyc", done_cyc, e0 + 17);
      chk("stall_done_cnt", done_cnt, 1);
      check_burst("stall", VL);

      // ---------------- start while busy ----------------
      reset_log();
      for (int i = 0; i < AS; i++) load_row(i, VL, VL, 0);
      @(negedge s_clk);
      pulse_start(e0);
      wait_cyc(e0 + 4);
      bus.start = 1'b1;
      @(negedge s_clk);
      bus.start = 1'b0;
      wait_cyc(e0 + 13);
      chk("busy_in_done_state", dbg_a, ST_DONE);
      bus.start = 1'b1;
      @(negedge s_clk);
      bus.start = 1'b0;
      wait_cyc(e0 + 30);
      chk("busy_done_cnt", done_cnt, 1);
      chk("busy_done_cyc", done_cyc, e0 + 14);
      chk("busy_no_restart", ren_tr[e0 + 15], 0);
      chk("busy_idle_state", dbg_a, ST_IDLE);
      chk("busy_low", bus.busy, 0);
      check_burst("busy", VL);

      // ---------------- clear mid-burst ----------------
      reset_log();
      for (int i = 0; i < AS; i++) load_row(i, VL, VL, 0);
      @(negedge s_clk);
      pulse_start(e0);
      wait_cyc(e0 + 4);
      chk("abort_busy_before", bus.busy, 1);
      chk("abort_r_en_before", bus.r_en, 3'b111);
      #1 clear = 1'b1;
      #1;
      chk("abort_r_en", bus.r_en, 0);
      chk("abort_row_valid", bus.row_valid, 0);
      chk("abort_row_data", bus.row_data, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_state", dbg_a, ST_IDLE);
      @(negedge s_clk);
      clear = 1'b0;
      for (int i = 0; i < AS; i++) begin
         fq[i].delete();
         exp_q[i].delete();
      end
      repeat (3) @(negedge s_clk);
      chk("abort_not_resumed", bus.r_en, 0);
      reset_log();
      for (int i = 0; i < AS; i++) load_row(i, VL, VL, 0);
      @(negedge s_clk);
      pulse_start(e1);
      wait_done(40);
      chk("abort_done_cyc", done_cyc, e1 + 14);
      check_burst("after_abort", VL);

      // ---------------- back-to-back bursts ----------------
      reset_log();
      for (int i = 0; i < AS; i++) load_row(i, 2 * VL, 2 * VL, 0);
      @(negedge s_clk);
      pulse_start(e0);
      wait_cyc(e0 + 14);
      chk("b2b_first_done", bus.done, 1);
      pulse_start(e1);
      chk("b2b_second_start", e1, e0 + 15);
      wait_cyc(e1 + 16);
      chk("b2b_done_cnt", done_cnt, 2);
      chk("b2b_done_cyc", done_cyc, e1 + 14);
      chk("b2b_ren_gap", ren_tr[e1 - 1], 0);
      chk("b2b_ren_first", ren_tr[e1], 3'b001);
      chk("b2b_ren_row2_last", ren_tr[e1 + 10], 3'b100);
      chk("b2b_ren_end", ren_tr[e1 + 11], 0);
      chk("b2b_rv_first", rv_tr[e1 + 2], 3'b001);
      chk("b2b_rv_row2_last", rv_tr[e1 + 12], 3'b100);
      chk("b2b_rv_end", rv_tr[e1 + 13], 0);
      check_burst("b2b", 2 * VL);
      mon_en = 1'b0;

      // ---------------- 1x1 instance, table driven ----------------
      @(negedge s_clk);
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge s_clk);
         chk($sformatf("corner_c%0d_r_en", c), bus_b.r_en, cv[c].r_en);
         chk($sformatf("corner_c%0d_valid", c), bus_b.row_valid, cv[c].rv);
         chk($sformatf("corner_c%0d_data", c), bus_b.row_data, cv[c].data);
         chk($sformatf("corner_c%0d_busy", c), bus_b.busy, cv[c].busy);
         chk($sformatf("corner_c%0d_done", c), bus_b.done, cv[c].done);
         bus_b.start = cv[c].start;
      end
      bus_b.start = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
